ram_scanner: RTL and testbench
==============================

# ram_scanner

Parametrised dual-port memory explorer for the DE1-SoC lab designs, successor to the single-port switch-driven memory top.
- Write port: one word per rising edge of a synchronous write request.
- Read port: auto-scans every address at a programmable tick rate (scan mode), or follows a manual read address.
- Clears the whole array after reset.
- Sits between switch/key synchronisers and the seg7 display decoders; outputs are raw binary.

## Interface
Parameters:
- DATA_W, default 3: word width in bits.
- ADDR_W, default 5: address width; DEPTH = 2**ADDR_W.
- TICK_CYCLES, default 50_000_000: clk cycles per scan step; must be ≥ 2.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_req  in  1  write request level, already synchronised upstream; only the rising edge is acted on.
- mode  in  1  0 = scan, 1 = manual read.
- rd_addr_man  in  ADDR_W  manual read address.
- rd_addr  out  ADDR_W  address currently being read.
- rd_data  out  DATA_W  mem[rd_addr], registered.
- wr_done  out  1  one-cycle pulse after each accepted write.
- busy  out  1  high while the clear sequence runs.

## Operation
State machine states: CLEAR, RUN.

CLEAR:
- Entered on any cycle with reset high.
- Writes 0 to addresses 0, 1, … DEPTH-1, one per cycle, using clr_addr.
- After writing DEPTH-1, moves to RUN.
- busy = 1 throughout; wr_req edges are discarded.

RUN:
- wr_req edge detection: prev ← wr_req every cycle, including during CLEAR.
- Write when wr_req & ~prev: mem[wr_addr] ← wr_data. A request held high across the end of CLEAR does not write.
- Tick counter counts 0..TICK_CYCLES-1 and wraps; it runs in both modes.
- In mode 0, scan_addr advances by 1 on the wrap cycle, DEPTH-1 → 0.
- In mode 1, scan_addr holds.
- rd_addr = scan_addr in mode 0, rd_addr_man in mode 1 (combinational mux).
- Mode 1 → 0 resumes from the held scan_addr.

Read-during-write to the same address returns the old word; the new word is visible one cycle later.

Width rules:
- scan_addr and clr_addr wrap naturally at ADDR_W bits.
- The tick counter is sized $clog2(TICK_CYCLES).

## Timing
Reset values (cycle after reset high): state = CLEAR, clr_addr = 0, scan_addr = 0, tick = 0, prev = 0, rd_data = 0, wr_done = 0, busy = 1.

- Clear: occupies exactly DEPTH cycles after reset deasserts. busy falls on the cycle the state becomes RUN.
- Reset mid-CLEAR or mid-RUN: restarts the clear from address 0; memory contents are not otherwise preserved.
- Write: edge sampled at clock N, memory written at N, wr_done high during N+1 only.
- Back-to-back writes: minimum spacing is 2 cycles (low-high toggle).
- Read latency: 1 cycle; rd_data at N+1 reflects rd_addr at N.
- Tick counter: starts counting in RUN and is held at 0 during CLEAR.
- First scan step: at the first wrap, TICK_CYCLES cycles after entering RUN.
- A write and a scan step in the same cycle are independent; both take effect.

## Structure
- Package ram_scanner_pkg holds the state enum type (CLEAR, RUN).
- Sub-module ram_dp (DATA_W, ADDR_W): simple dual-port synchronous RAM with one write port and one registered read port, read-before-write. It infers M10K.
- ram_scanner holds the FSM, clear counter, edge detector, tick counter, scan counter and address mux.
- The write port mux (clear vs user) lives in ram_scanner.

## Test plan
Bench parameters: DATA_W = 3, ADDR_W = 3, TICK_CYCLES = 4.

1. Reset, then clear:
   - Stimulus: pulse reset 1 cycle; preload a nonzero word before reset.
   - Required: busy high for 8 cycles then low; every address reads 0 afterwards.
2. Write, then manual read:
   - Stimulus: mode = 1, wr_addr = 5, wr_data = 6, wr_req held high for 3 cycles; rd_addr_man = 5.
   - Required: one wr_done pulse only; rd_data = 6.
3. Scan wrap:
   - Stimulus: write 7 at address 0; mode = 0.
   - Required: rd_addr steps every 4 cycles 0..7 then back to 0; rd_data = 7 at address 0 after the wrap.
4. Request held through reset:
   - Stimulus: wr_req high before and during CLEAR, released after busy falls.
   - Required: no write and no wr_done; next rising edge writes normally.
5. Collision:
   - Stimulus: manual rd_addr_man = 2, write 3 to address 2.
   - Required: rd_data shows the old 0 for one cycle, then 3.
6. Mode hold and reset mid-run:
   - Stimulus: scan to address 4, switch to mode 1 for 20 cycles, return to mode 0.
   - Required: scanning resumes at 4.
   - Stimulus: reset during RUN.
   - Required: busy = 1, rd_addr = 0, all memory zeroed after 8 cycles.

Source files
------------

// File: rtl/ram_scanner_pkg.sv
// Shared types for the ram_scanner memory explorer.
// CLEAR zeroes the array after reset; RUN serves user writes and scanning.
package ram_scanner_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/ram_dp.sv
// Simple dual-port synchronous RAM with one write port and one registered read port.
// A read and a write to the same address in one cycle return the old word.
module ram_dp #(
  parameter int DATA_W = 3,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Both ports update with non-blocking assignments, so the read sees the pre-write word.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_reset) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_scanner.sv
// Dual-port memory explorer: clears the RAM after reset, writes on wr_req rising edges,
// and reads either an auto-scanned address or a manually selected one.
module ram_scanner
  import ram_scanner_pkg::*;
#(
  parameter int DATA_W      = 3,
  parameter int ADDR_W      = 5,
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_req,
  input  logic              mode,
  input  logic [ADDR_W-1:0] rd_addr_man,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              wr_done,
  output logic              busy
);

  localparam int                TICK_W    = $clog2(TICK_CYCLES);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] r_scan_addr;
  logic [TICK_W-1:0] r_tick;
  logic              r_prev;
  logic              r_wr_done;

  logic              w_busy;
  logic              w_wr_accept;
  logic              w_tick_wrap;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;

  assign w_tick_wrap = (r_tick == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The write port belongs to the clear sequence in CLEAR and to the user in RUN.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_wr_accept  = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_waddr  = wr_addr;
    w_mem_wdata  = wr_data;
    case (r_state)
      CLEAR: begin
        w_busy      = 1'b1;
        w_mem_we    = ~reset;
        w_mem_waddr = r_clr_addr;
        w_mem_wdata = '0;
        if (r_clr_addr == '1) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_wr_accept = wr_req & ~r_prev & ~reset;
        w_mem_we    = w_wr_accept;
      end
      default: begin
        w_state_next = CLEAR;
      end
    endcase
  end

  // prev keeps sampling during CLEAR so a request held across the clear is not seen as an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_addr  <= '0;
      r_scan_addr <= '0;
      r_tick      <= '0;
      r_prev      <= 1'b0;
      r_wr_done   <= 1'b0;
    end else begin
      r_prev    <= wr_req;
      r_wr_done <= w_wr_accept;
      if (r_state == CLEAR) begin
        r_clr_addr <= r_clr_addr + 1'b1;
        r_tick     <= '0;
      end else begin
        r_tick <= w_tick_wrap ? '0 : r_tick + 1'b1;
        if (w_tick_wrap && !mode) begin
          r_scan_addr <= r_scan_addr + 1'b1;
        end
      end
    end
  end

  assign rd_addr = mode ? rd_addr_man : r_scan_addr;
  assign wr_done = r_wr_done;
  assign busy    = w_busy;

  ram_dp #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .i_clk  (clk),
    .i_reset(reset),
    .i_we   (w_mem_we),
    .i_waddr(w_mem_waddr),
    .i_wdata(w_mem_wdata),
    .i_raddr(rd_addr),
    .o_rdata(rd_data)
  );

endmodule

// File: tb/tb_ram_scanner.sv
// Scoreboard bench for ram_scanner (DATA_W=3, ADDR_W=3, TICK_CYCLES=4).
// Stimulus queues cycle-stamped expectations; negedge monitors pop and compare them.
module tb_ram_scanner;

  localparam int K_BUSY   = 0;
  localparam int K_RDADDR = 1;
  localparam int K_RDDATA = 2;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [2:0] wr_addr;
  logic [2:0] wr_data;
  logic       wr_req;
  logic       mode;
  logic [2:0] rd_addr_man;
  logic [2:0] rd_addr;
  logic [2:0] rd_data;
  logic       wr_done;
  logic       busy;

  int   cyc = 0;
  int   runStart = 0;
  int   errors = 0;
  int   checks = 0;
  int   memModel [8];
  exp_t scbQ [$];
  int   wrDoneQ [$];

  ram_scanner #(
    .DATA_W(3),
    .ADDR_W(3),
    .TICK_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_req     (wr_req),
    .mode       (mode),
    .rd_addr_man(rd_addr_man),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_done    (wr_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic string kindName(input int kind);
    case (kind)
      K_BUSY:   return "busy";
      K_RDADDR: return "rd_addr";
      default:  return "rd_data";
    endcase
  endfunction

  task automatic checkOutput(input int kind, input int val);
    logic [7:0] act;
    case (kind)
      K_BUSY:   act = {7'b0, busy};
      K_RDADDR: act = {5'b0, rd_addr};
      default:  act = {5'b0, rd_data};
    endcase
    checks++;
    if (act !== 8'(val)) begin
      errors++;
      $display("[TB] FAIL %s @cyc %0d: got %0h expected %0h", kindName(kind), cyc, act, val);
    end
  endtask

  // Value monitor: compares every expectation stamped with the current cycle.
  always @(negedge clk) begin
    for (int i = scbQ.size() - 1; i >= 0; i--) begin
      if (scbQ[i].cyc == cyc) begin
        checkOutput(scbQ[i].kind, scbQ[i].val);
        scbQ.delete(i);
      end else if (scbQ[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s stale @cyc %0d: got unchecked expected %0h", kindName(scbQ[i].kind), scbQ[i].cyc, scbQ[i].val);
        scbQ.delete(i);
      end
    end
  end

  // Write-completion monitor: every wr_done pulse must match a queued write, and vice versa.
  always @(negedge clk) begin
    while (wrDoneQ.size() > 0 && wrDoneQ[0] < cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL wr_done missing: got 0 @cyc %0d expected 1", wrDoneQ[0]);
      void'(wrDoneQ.pop_front());
    end
    if (wr_done === 1'b1) begin
      checks++;
      if (wrDoneQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL wr_done unexpected: got 1 @cyc %0d expected 0", cyc);
      end else begin
        void'(wrDoneQ.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expectAt(input int off, input int kind, input int val);
    scbQ.push_back('{cyc + off, kind, val});
  endtask

  task automatic applyStimulus(input logic req, input logic [2:0] wa, input logic [2:0] wd,
                               input logic m, input logic [2:0] man);
    step();
    wr_req      = req;
    wr_addr     = wa;
    wr_data     = wd;
    mode        = m;
    rd_addr_man = man;
  endtask

  task automatic doReset(input logic holdReq);
    step();
    reset  = 1'b1;
    wr_req = holdReq;
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) expectAt(i, K_BUSY, 1);
    expectAt(8, K_BUSY, 0);
    expectAt(0, K_RDDATA, 0);
    if (mode == 1'b0) begin
      for (int i = 0; i < 8; i++) expectAt(i, K_RDADDR, 0);
    end
    for (int i = 0; i < 8; i++) memModel[i] = 0;
    repeat (8) step();
    runStart = cyc;
  endtask

  task automatic writeWord(input logic [2:0] a, input logic [2:0] d);
    applyStimulus(1'b1, a, d, mode, rd_addr_man);
    wrDoneQ.push_back(cyc + 1);
    memModel[a] = int'(d);
    applyStimulus(1'b0, a, d, mode, rd_addr_man);
  endtask

  task automatic readAddr(input logic [2:0] a);
    applyStimulus(1'b0, wr_addr, wr_data, 1'b1, a);
    expectAt(0, K_RDADDR, int'(a));
    expectAt(1, K_RDDATA, memModel[a]);
  endtask

  task automatic readAll();
    for (int a = 0; a < 8; a++) readAddr(3'(a));
    step();
  endtask

  initial begin
    int p;
    int scanExp;
    int rdExp;
    logic m;

    reset       = 1'b1;
    wr_req      = 1'b0;
    wr_addr     = 3'd0;
    wr_data     = 3'd0;
    mode        = 1'b1;
    rd_addr_man = 3'd0;

    // Reset and clear, with a nonzero word loaded before the second reset.
    doReset(1'b0);
    writeWord(3'd3, 3'd5);
    readAddr(3'd3);
    step();
    doReset(1'b0);
    readAll();

    // Request held high three cycles produces a single write.
    applyStimulus(1'b0, 3'd0, 3'd0, 1'b1, 3'd5);
    applyStimulus(1'b1, 3'd5, 3'd6, 1'b1, 3'd5);
    p = cyc;
    wrDoneQ.push_back(p + 1);
    memModel[5] = 6;
    expectAt(0, K_RDADDR, 5);
    expectAt(1, K_RDDATA, 0);
    expectAt(2, K_RDDATA, 6);
    expectAt(3, K_RDDATA, 6);
    step();
    step();
    applyStimulus(1'b0, 3'd5, 3'd6, 1'b1, 3'd5);
    step();

    // Same-address read during write returns the old word first.
    applyStimulus(1'b0, 3'd0, 3'd0, 1'b1, 3'd2);
    applyStimulus(1'b1, 3'd2, 3'd3, 1'b1, 3'd2);
    wrDoneQ.push_back(cyc + 1);
    expectAt(1, K_RDDATA, 0);
    expectAt(2, K_RDDATA, 3);
    memModel[2] = 3;
    applyStimulus(1'b0, 3'd2, 3'd3, 1'b1, 3'd2);
    step();
    step();

    // Full scan wrap, then a 20-cycle manual hold at address 4 and resume.
    writeWord(3'd0, 3'd7);
    step();
    while (((cyc - runStart) % 4) != 0) step();
    scanExp = 0;
    for (int k = 0; k < 76; k++) begin
      if (k > 0) step();
      m = (k >= 48 && k < 68);
      mode        = m;
      rd_addr_man = 3'd1;
      rdExp = m ? 1 : scanExp;
      expectAt(0, K_RDADDR, rdExp);
      expectAt(1, K_RDDATA, memModel[rdExp]);
      if ((k % 4) == 3 && !m) scanExp = (scanExp + 1) % 8;
    end
    step();

    // Reset during RUN in scan mode restarts the clear with rd_addr at 0.
    mode = 1'b0;
    doReset(1'b0);
    readAll();

    // Request raised with reset and held through the clear must not write.
    applyStimulus(1'b0, 3'd6, 3'd5, 1'b1, 3'd6);
    doReset(1'b1);
    applyStimulus(1'b1, 3'd6, 3'd5, 1'b1, 3'd6);
    applyStimulus(1'b0, 3'd6, 3'd5, 1'b1, 3'd6);
    step();
    readAddr(3'd6);
    step();
    writeWord(3'd6, 3'd5);
    readAddr(3'd6);
    step();
    step();
    step();

    while (wrDoneQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL wr_done missing at end: got 0 expected 1 @cyc %0d", wrDoneQ.pop_front());
    end
    while (scbQ.size() > 0) begin
      exp_t e;
      e = scbQ.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL %s unchecked at end: got none expected %0h", kindName(e.kind), e.val);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
